// File: rtl/noc_pkg.sv
// Shared leaf-group NoC types: flit/header geometry and upstream poll FSM encoding.
// Pure declarations: no latency, no backpressure.
package noc_pkg;
    localparam int DATA_W   = 16;
    localparam int HEADER_W = 6;
    localparam int GROUP_W  = 4;
    localparam int LEAF_W   = 2;
    localparam int NUM_LEAF = 4;

    // Routing header occupies the top HEADER_W bits of every flit
    localparam int HDR_MSB = DATA_W - 1;
    localparam int HDR_LSB = DATA_W - HEADER_W;

    typedef enum logic [1:0] {
        POLL = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } up_state_e;

    typedef struct packed {
        logic [GROUP_W-1:0] group;
        logic [LEAF_W-1:0]  leaf;
    } hdr_t;

    function automatic hdr_t get_hdr(input logic [DATA_W-1:0] flit);
        return hdr_t'(flit[HDR_MSB:HDR_LSB]);
    endfunction
endpackage

// File: rtl/leaf_demux.sv
// Downstream group match and leaf decode; delivers router flits to one NI, counts misroutes.
// Latency 1 cycle (registered strobe + data); no backpressure, every dn_valid flit is delivered or dropped.
module leaf_demux
    import noc_pkg::*;
#(
    parameter logic [GROUP_W-1:0] GROUP_ID = 4'd5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_W-1:0]          dn_data,
    input  logic                       dn_valid,
    output logic [NUM_LEAF*DATA_W-1:0] ni_data_out,
    output logic [NUM_LEAF-1:0]        ni_valid_out,
    output logic [7:0]                 drop_cnt
);
    hdr_t                       hdr;
    logic                       hit;
    logic [NUM_LEAF*DATA_W-1:0] data_q, data_d;
    logic [NUM_LEAF-1:0]        vld_q, vld_d;
    logic [7:0]                 drop_q, drop_d;

    assign hdr = get_hdr(dn_data);
    assign hit = dn_valid && (hdr.group == GROUP_ID);

    always_comb begin
        data_d = data_q;
        vld_d  = '0;
        drop_d = drop_q;
        if (hit) begin
            vld_d = NUM_LEAF'(1) << hdr.leaf;
            for (int i = 0; i < NUM_LEAF; i++) begin
                if (hdr.leaf == LEAF_W'(i)) begin
                    data_d[i*DATA_W +: DATA_W] = dn_data;
                end
            end
        end else if (dn_valid && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            vld_q  <= '0;
            drop_q <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            drop_q <= drop_d;
        end
    end

    assign ni_data_out  = data_q;
    assign ni_valid_out = vld_q;
    assign drop_cnt     = drop_q;
endmodule

// File: rtl/leaf_group_arbiter.sv
// Round-robin pull arbiter of four NIs onto one router port, plus downstream steering via leaf_demux.
// Upstream: poll->flit on up_valid 2 cycles later, held until up_ready; downstream: 1 cycle, no backpressure.
module leaf_group_arbiter
    import noc_pkg::*;
#(
    parameter logic [GROUP_W-1:0] GROUP_ID = 4'd5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_LEAF*DATA_W-1:0] ni_data_in,
    input  logic [NUM_LEAF-1:0]        ni_valid_in,
    output logic [NUM_LEAF-1:0]        ni_ready_out,
    output logic [DATA_W-1:0]          up_data,
    output logic                       up_valid,
    input  logic                       up_ready,
    input  logic [DATA_W-1:0]          dn_data,
    input  logic                       dn_valid,
    output logic [NUM_LEAF*DATA_W-1:0] ni_data_out,
    output logic [NUM_LEAF-1:0]        ni_valid_out,
    output logic [7:0]                 drop_cnt,
    output logic [LEAF_W-1:0]          cur_port
);
    up_state_e          state_q, state_d;
    logic [LEAF_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0]  sel_dat;
    logic               sel_vld;

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_LEAF; i++) begin
            if (ptr_q == LEAF_W'(i)) begin
                sel_dat = ni_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_vld = ni_valid_in[ptr_q];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        ni_ready_out = '0;
        up_valid     = 1'b0;
        case (state_q)
            POLL: begin
                // Reset parks the FSM in POLL; gating keeps the pull strobe low until release
                ni_ready_out = reset_n ? (NUM_LEAF'(1) << ptr_q) : '0;
                state_d      = WAIT;
            end
            WAIT: begin
                if (sel_vld) begin
                    hold_d  = sel_dat;
                    state_d = SEND;
                end else begin
                    ptr_d   = ptr_q + LEAF_W'(1);
                    state_d = POLL;
                end
            end
            SEND: begin
                up_valid = 1'b1;
                if (up_ready) begin
                    ptr_d   = ptr_q + LEAF_W'(1);
                    state_d = POLL;
                end
            end
            default: begin
                state_d = POLL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= POLL;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign up_data  = hold_q;
    assign cur_port = ptr_q;

    leaf_demux #(
        .GROUP_ID (GROUP_ID)
    ) u_leaf_demux (
        .clk          (clk),
        .reset_n      (reset_n),
        .dn_data      (dn_data),
        .dn_valid     (dn_valid),
        .ni_data_out  (ni_data_out),
        .ni_valid_out (ni_valid_out),
        .drop_cnt     (drop_cnt)
    );
endmodule

// File: tb/tb_leaf_group_arbiter.sv
// Scoreboard bench for leaf_group_arbiter: NI pull models, random traffic, round-robin and delivery checks.
`timescale 1ns/1ps
module tb_leaf_group_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] ni_data_in = '0;
    logic [3:0]  ni_valid_in = '0;
    logic [3:0]  ni_ready_out;
    logic [15:0] up_data;
    logic        up_valid;
    logic        up_ready = 1'b0;
    logic [15:0] dn_data = '0;
    logic        dn_valid = 1'b0;
    logic [63:0] ni_data_out;
    logic [3:0]  ni_valid_out;
    logic [7:0]  drop_cnt;
    logic [1:0]  cur_port;

    always #5 clk = ~clk;

    leaf_group_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ni_data_in   (ni_data_in),
        .ni_valid_in  (ni_valid_in),
        .ni_ready_out (ni_ready_out),
        .up_data      (up_data),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .dn_data      (dn_data),
        .dn_valid     (dn_valid),
        .ni_data_out  (ni_data_out),
        .ni_valid_out (ni_valid_out),
        .drop_cnt     (drop_cnt),
        .cur_port     (cur_port)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // NI FIFOs and pull-protocol state
    logic [15:0] fbuf [4][64];
    int          fhead [4];
    int          ftail [4];
    logic [3:0]  pend_vld = '0;
    logic [15:0] pend_dat [4];
    logic [3:0]  quiet = '0;

    typedef struct { logic [15:0] d; int pc; } up_exp_t;
    typedef struct { int due; logic [3:0] mask; logic [1:0] port; logic [15:0] d; logic [7:0] drop; } dn_exp_t;
    up_exp_t up_q[$];
    dn_exp_t dn_q[$];
    int      exp_drop = 0;

    int          up_mode = 0;
    int          stall_left = 0;
    int          dn_mode = 0;
    int          dn_force_n = 0;
    logic [15:0] dn_force_val = '0;
    bit          gb_en = 1'b0;

    bit          mon_en = 1'b0;
    int          exp_port = 0;
    int          poll_due = -1;
    bit          in_send = 1'b0;
    logic [15:0] cur_exp = '0;

    task automatic push_flit(input int port, input logic [15:0] d);
        fbuf[port][ftail[port] % 64] = d;
        ftail[port]++;
    endtask

    task automatic wait_up(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < n && !ok; k++) begin
            @(negedge clk);
            if (up_valid) ok = 1'b1;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3;
        reset_n  = 1'b1;
        exp_port = 0;
        poll_due = cyc;
        in_send  = 1'b0;
        mon_en   = 1'b1;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 4; i++) begin
            fhead[i] = ftail[i];
        end
        pend_vld = '0;
        quiet    = '0;
        up_q.delete();
        dn_q.delete();
        exp_drop = 0;
        in_send  = 1'b0;
    endtask

    function automatic bit all_drained();
        bit e;
        e = (up_q.size() == 0) && !in_send && (pend_vld == 4'b0);
        for (int i = 0; i < 4; i++) begin
            if (fhead[i] != ftail[i]) e = 1'b0;
        end
        return e;
    endfunction

    // NI model: pops its FIFO in the cycle it sees ready; the flit is expected upstream
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                for (int i = 0; i < 4; i++) begin
                    if (ni_ready_out[i]) begin
                        quiet[i] = 1'b1;
                        if (fhead[i] != ftail[i]) begin
                            pend_dat[i] = fbuf[i][fhead[i] % 64];
                            fhead[i]++;
                            pend_vld[i] = 1'b1;
                            up_q.push_back('{d: pend_dat[i], pc: cyc});
                        end
                    end
                end
            end
        end
    end

    // Driver: NI valid for one cycle after a pop, router ready, router downstream flits
    initial begin
        dn_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (quiet[i] || !gb_en) begin
                    ni_valid_in[i]        = pend_vld[i];
                    ni_data_in[i*16 +: 16] = pend_dat[i];
                end else begin
                    ni_valid_in[i]        = 1'($urandom_range(0, 1));
                    ni_data_in[i*16 +: 16] = 16'($urandom);
                end
                pend_vld[i] = 1'b0;
                quiet[i]    = 1'b0;
            end
            case (up_mode)
                0: up_ready = 1'b1;
                1: up_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (up_valid && cur_port == 2'd1 && stall_left > 0) begin
                        up_ready = 1'b0;
                        stall_left--;
                    end else begin
                        up_ready = 1'b1;
                    end
                end
                default: up_ready = 1'b0;
            endcase
            dn_valid = 1'b0;
            dn_data  = 16'($urandom);
            case (dn_mode)
                1: begin
                    dn_valid = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 2) != 0) dn_data[15:12] = 4'd5;
                end
                2: begin
                    if (dn_force_n > 0) begin
                        dn_valid = 1'b1;
                        dn_data  = dn_force_val;
                        dn_force_n--;
                    end
                end
                3: begin
                    dn_valid       = 1'b1;
                    dn_data[15:12] = 4'h3;
                end
                default: ;
            endcase
            if (reset_n) begin
                e.due  = cyc + 1;
                e.mask = 4'b0000;
                e.port = dn_data[11:10];
                e.d    = dn_data;
                if (dn_valid) begin
                    if (dn_data[15:12] == 4'd5) e.mask = 4'b0001 << dn_data[11:10];
                    else if (exp_drop < 255) exp_drop++;
                end
                e.drop = 8'(exp_drop);
                dn_q.push_back(e);
            end
        end
    end

    // Monitor: upstream order/latency/hold, poll schedule, downstream delivery and drop count
    initial begin
        up_exp_t u;
        dn_exp_t d;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n) begin
                if (up_valid) begin
                    if (!in_send) begin
                        check("up_flit_expected", 64'(up_q.size() != 0), 64'd1);
                        if (up_q.size() != 0) begin
                            u = up_q.pop_front();
                            check("up_latency", 64'(cyc - u.pc), 64'd2);
                            check("up_data", up_data, u.d);
                            cur_exp = u.d;
                        end
                        in_send  = 1'b1;
                        poll_due = -1;
                    end else begin
                        check("up_data_hold", up_data, cur_exp);
                    end
                    if (up_ready) begin
                        in_send  = 1'b0;
                        poll_due = cyc + 1;
                    end
                end else if (in_send) begin
                    check("up_valid_held", up_valid, 1'b1);
                    in_send = 1'b0;
                end
                if (ni_ready_out != 4'b0 || cyc == poll_due) begin
                    check("poll_port", ni_ready_out, 4'b0001 << exp_port);
                    check("poll_time", 64'(cyc), 64'(poll_due));
                    if (ni_ready_out != 4'b0) begin
                        exp_port = (exp_port + 1) % 4;
                        poll_due = cyc + 2;
                    end
                end
                if (dn_q.size() != 0 && dn_q[0].due == cyc) begin
                    d = dn_q.pop_front();
                    check("dn_valid_out", ni_valid_out, d.mask);
                    if (d.mask != 4'b0) check("dn_data_out", ni_data_out[d.port*16 +: 16], d.d);
                    check("drop_cnt", drop_cnt, d.drop);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 4; i++) begin
            fhead[i]    = 0;
            ftail[i]    = 0;
            pend_dat[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", ni_ready_out, 4'b0);
        check("rst_up_valid", up_valid, 1'b0);
        check("rst_up_data", up_data, 16'h0);
        check("rst_valid_out", ni_valid_out, 4'b0);
        check("rst_data_out", ni_data_out, 64'h0);
        check("rst_drop", drop_cnt, 8'd0);
        check("rst_cur_port", cur_port, 2'd0);
        release_reset();

        // Idle polling: monitor enforces 1-hot sequence every 2 cycles and no up_valid
        repeat (24) @(posedge clk);

        // Single flit from NI2
        push_flit(2, 16'h5823);
        wait_up(40, ok);
        check("n2_seen", ok, 1'b1);
        check("n2_data", up_data, 16'h5823);
        check("n2_port", cur_port, 2'd2);
        repeat (12) @(posedge clk);

        // All NIs full, 5-cycle stall during port 1 send
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) push_flit(p, 16'($urandom));
        end
        stall_left = 5;
        up_mode    = 2;
        repeat (60) @(posedge clk);
        check("stall_applied", 64'(stall_left), 64'd0);

        // Random traffic both directions with stray valids on unpolled ports
        gb_en   = 1'b1;
        up_mode = 1;
        dn_mode = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = $urandom_range(0, 3);
                if (ftail[p] - fhead[p] < 32) push_flit(p, 16'($urandom));
            end
        end
        up_mode = 0;
        dn_mode = 0;
        ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(negedge clk);
            if (all_drained()) ok = 1'b1;
        end
        check("drained", ok, 1'b1);
        gb_en = 1'b0;

        // Directed downstream delivery to leaf 2
        @(negedge clk);
        dn_force_val = 16'h5A5A;
        dn_force_n   = 1;
        dn_mode      = 2;
        repeat (2) @(negedge clk);
        check("dn5a_valid", ni_valid_out, 4'b0100);
        check("dn5a_data", ni_data_out[47:32], 16'h5A5A);
        check("dn5a_drop", drop_cnt, 8'(exp_drop));
        dn_mode = 0;

        // Saturating drop counter
        dn_mode = 3;
        repeat (300) @(posedge clk);
        dn_mode = 0;
        repeat (3) @(negedge clk);
        check("drop_sat", drop_cnt, 8'd255);

        // Asynchronous reset while a flit sits in SEND
        up_mode = 3;
        for (int p = 0; p < 4; p++) push_flit(p, 16'($urandom));
        wait_up(40, ok);
        check("rst_send_seen", ok, 1'b1);
        @(posedge clk);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_up_valid", up_valid, 1'b0);
        check("arst_up_data", up_data, 16'h0);
        check("arst_ready", ni_ready_out, 4'b0);
        check("arst_data_out", ni_data_out, 64'h0);
        check("arst_drop", drop_cnt, 8'd0);
        check("arst_cur_port", cur_port, 2'd0);
        clear_models();
        up_mode = 0;
        repeat (2) @(posedge clk);
        release_reset();
        push_flit(1, 16'hC3A1);
        repeat (20) @(posedge clk);
        check("post_rst_drained", all_drained(), 1'b1);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
